// File: rtl/chronologic.sv
// chronologic: on-chip temporal-implication monitor.
// Every edge that samples a=1 while en=1 opens an obligation. The obligation
// requires b=1 exactly DELAY edges later. When an obligation matures, the block
// emits a one-cycle pass or fail pulse, updates saturating counters, and
// captures the trigger index of the first failure.
//
// Parameters:
//   DELAY  edges between trigger sample and response sample (1..64)
//   CNT_W  width of counters and of the cycle index
// Ports:
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   en                allows new obligations to start
//   clr               synchronous clear of all state (wins over a trigger)
//   a, b              trigger and response
//   pass, fail        one-cycle result pulses for a matured obligation
//   pass_cnt          saturating count of passes
//   fail_cnt          saturating count of failures
//   cycle_idx         index of the next edge (wraps)
//   err_sticky        set by the first failure
//   first_fail_valid  first_fail_cycle is meaningful
//   first_fail_cycle  trigger-edge index of the first failing obligation
//   busy              at least one obligation is pending
module chronologic #(
  parameter int DELAY = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] cycle_idx,
  output logic             err_sticky,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_cycle,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DELAY_W = CNT_W'(DELAY);

  logic [DELAY-1:0] pend;
  logic [DELAY-1:0] pend_next;
  logic             matured;
  logic             hit;
  logic             miss;

  // Each bit of pend is one outstanding obligation, aged by its position. The
  // shift-left form also covers DELAY=1, where no slice of pend would exist.
  always_comb begin
    pend_next = (pend << 1) | DELAY'(en & a);
    matured   = pend[DELAY-1];
    hit       = matured & b;
    miss      = matured & ~b;
  end

  // The oldest obligation is judged against b at the same edge that would
  // shift it out. cycle_idx still holds the index of this edge, so subtracting
  // DELAY gives the trigger index of the failing obligation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend             <= '0;
      busy             <= 1'b0;
      pass             <= 1'b0;
      fail             <= 1'b0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      cycle_idx        <= '0;
      err_sticky       <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_cycle <= '0;
    end else if (clr) begin
      pend             <= '0;
      busy             <= 1'b0;
      pass             <= 1'b0;
      fail             <= 1'b0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      cycle_idx        <= '0;
      err_sticky       <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_cycle <= '0;
    end else begin
      pend      <= pend_next;
      busy      <= |pend_next;
      cycle_idx <= cycle_idx + CNT_W'(1);
      pass      <= hit;
      fail      <= miss;
      if (hit && (pass_cnt != CNT_MAX)) begin
        pass_cnt <= pass_cnt + CNT_W'(1);
      end
      if (miss) begin
        if (fail_cnt != CNT_MAX) begin
          fail_cnt <= fail_cnt + CNT_W'(1);
        end
        err_sticky <= 1'b1;
        if (!first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_cycle <= cycle_idx - DELAY_W;
        end
      end
    end
  end

endmodule

// File: tb/tb_chronologic.sv
// tb_chronologic: scoreboard bench for chronologic.
// Two instances share the clock and reset: inst 0 (DELAY=8, CNT_W=16) and
// inst 1 (DELAY=4, CNT_W=4), which exercises saturation and index wrap. A
// behavioural model keeps obligations on a timing wheel keyed by their due
// edge and remembers each trigger's index. Expected outputs are queued when an
// edge's stimulus is driven, then popped and compared 1ns after that edge.
module tb_chronologic;

  localparam int D0 = 8;
  localparam int D1 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic en, clr, a, b;
  logic s_en, s_clr, s_a, s_b;

  logic        pass_0, fail_0, err_0, ffv_0, busy_0;
  logic [15:0] pass_cnt_0, fail_cnt_0, idx_0, ffc_0;
  logic        pass_1, fail_1, err_1, ffv_1, busy_1;
  logic [3:0]  pass_cnt_1, fail_cnt_1, idx_1, ffc_1;

  typedef struct packed {
    logic        pass;
    logic        fail;
    logic        busy;
    logic        err;
    logic        ffv;
    logic [15:0] pc;
    logic [15:0] fc;
    logic [15:0] ffc;
    logic [15:0] idx;
  } exp_t;

  typedef struct packed {
    exp_t m;
    exp_t s;
  } pair_t;

  pair_t sb_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // Model state, one slot per instance.
  int          md_edge[2];
  int          md_out[2];
  logic [15:0] md_idx[2];
  logic [15:0] md_pc[2];
  logic [15:0] md_fc[2];
  logic [15:0] md_ffc[2];
  logic        md_err[2];
  logic        md_ffv[2];
  logic        md_due[2][128];
  logic [15:0] md_trig[2][128];

  always #5 clk = ~clk;

  chronologic #(.DELAY(D0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
    .pass(pass_0), .fail(fail_0), .pass_cnt(pass_cnt_0), .fail_cnt(fail_cnt_0),
    .cycle_idx(idx_0), .err_sticky(err_0), .first_fail_valid(ffv_0),
    .first_fail_cycle(ffc_0), .busy(busy_0)
  );

  chronologic #(.DELAY(D1), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(s_en), .clr(s_clr), .a(s_a), .b(s_b),
    .pass(pass_1), .fail(fail_1), .pass_cnt(pass_cnt_1), .fail_cnt(fail_cnt_1),
    .cycle_idx(idx_1), .err_sticky(err_1), .first_fail_valid(ffv_1),
    .first_fail_cycle(ffc_1), .busy(busy_1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelClear(input int k);
    for (int i = 0; i < 128; i++) begin
      md_due[k][i]  = 1'b0;
      md_trig[k][i] = '0;
    end
    md_out[k] = 0;
    md_idx[k] = '0;
    md_pc[k]  = '0;
    md_fc[k]  = '0;
    md_ffc[k] = '0;
    md_err[k] = 1'b0;
    md_ffv[k] = 1'b0;
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      modelClear(k);
      md_edge[k] = 0;
    end
  endtask

  task automatic modelStep(input int k, input int dly, input logic [15:0] msk,
                           input logic en_i, input logic a_i, input logic b_i,
                           input logic clr_i, output exp_t e);
    int slot;
    int due;
    slot = md_edge[k] % 128;
    e = '0;
    if (clr_i) begin
      modelClear(k);
    end else begin
      if (md_due[k][slot]) begin
        md_due[k][slot] = 1'b0;
        md_out[k]--;
        if (b_i) begin
          e.pass = 1'b1;
          if (md_pc[k] != msk) md_pc[k] = md_pc[k] + 16'd1;
        end else begin
          e.fail = 1'b1;
          if (md_fc[k] != msk) md_fc[k] = md_fc[k] + 16'd1;
          md_err[k] = 1'b1;
          if (!md_ffv[k]) begin
            md_ffv[k] = 1'b1;
            md_ffc[k] = md_trig[k][slot];
          end
        end
      end
      if (en_i && a_i) begin
        due = (md_edge[k] + dly) % 128;
        md_due[k][due]  = 1'b1;
        md_trig[k][due] = md_idx[k];
        md_out[k]++;
      end
      md_idx[k] = (md_idx[k] + 16'd1) & msk;
    end
    md_edge[k]++;
    e.busy = (md_out[k] > 0);
    e.err  = md_err[k];
    e.ffv  = md_ffv[k];
    e.pc   = md_pc[k];
    e.fc   = md_fc[k];
    e.ffc  = md_ffc[k];
    e.idx  = md_idx[k];
  endtask

  task automatic compareOutputs(input pair_t p);
    checkOutput("pulse0",    {30'b0, pass_0, fail_0}, {30'b0, p.m.pass, p.m.fail});
    checkOutput("pass_cnt0", {16'b0, pass_cnt_0}, {16'b0, p.m.pc});
    checkOutput("fail_cnt0", {16'b0, fail_cnt_0}, {16'b0, p.m.fc});
    checkOutput("flags0",    {29'b0, busy_0, err_0, ffv_0}, {29'b0, p.m.busy, p.m.err, p.m.ffv});
    checkOutput("ffc0",      {16'b0, ffc_0}, {16'b0, p.m.ffc});
    checkOutput("idx0",      {16'b0, idx_0}, {16'b0, p.m.idx});
    checkOutput("pulse1",    {30'b0, pass_1, fail_1}, {30'b0, p.s.pass, p.s.fail});
    checkOutput("cnt1",      {24'b0, pass_cnt_1, fail_cnt_1}, {24'b0, p.s.pc[3:0], p.s.fc[3:0]});
    checkOutput("flags1",    {29'b0, busy_1, err_1, ffv_1}, {29'b0, p.s.busy, p.s.err, p.s.ffv});
    checkOutput("idx1",      {24'b0, ffc_1, idx_1}, {24'b0, p.s.ffc[3:0], p.s.idx[3:0]});
  endtask

  // Drives one edge: the inputs currently on the bench variables are sampled.
  task automatic applyStimulus();
    exp_t  e0, e1;
    pair_t p;
    modelStep(0, D0, 16'hFFFF, en, a, b, clr, e0);
    modelStep(1, D1, 16'h000F, s_en, s_a, s_b, s_clr, e1);
    p.m = e0;
    p.s = e1;
    sb_q.push_back(p);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checkOutput("sb_empty", 32'd0, 32'd1);
    end else begin
      p = sb_q.pop_front();
      compareOutputs(p);
    end
  endtask

  task automatic checkResetZero();
    checkOutput("rst_flags0", {27'b0, pass_0, fail_0, busy_0, err_0, ffv_0}, 32'd0);
    checkOutput("rst_cnt0",   {pass_cnt_0, fail_cnt_0}, 32'd0);
    checkOutput("rst_idx0",   {ffc_0, idx_0}, 32'd0);
    checkOutput("rst_all1",   {11'b0, pass_1, fail_1, busy_1, err_1, ffv_1,
                               pass_cnt_1, fail_cnt_1, ffc_1, idx_1}, 32'd0);
  endtask

  // Called 1ns after an edge: asserts reset mid-cycle, checks, releases.
  task automatic asyncReset();
    #3;
    rst_n = 1'b0;
    #1;
    checkResetZero();
    #1;
    rst_n = 1'b1;
    modelReset();
    sb_q.delete();
  endtask

  task automatic idleMain();
    en = 1'b1; clr = 1'b0; a = 1'b0; b = 1'b0;
  endtask

  task automatic clrStep();
    clr = 1'b1;
    applyStimulus();
    clr = 1'b0;
  endtask

  initial begin
    idleMain();
    s_en = 1'b0; s_clr = 1'b0; s_a = 1'b0; s_b = 1'b0;
    modelReset();
    #12;
    checkResetZero();
    #10;
    rst_n = 1'b1;

    // Single pass: trigger at index 2, response at index 10.
    for (int i = 0; i < 15; i++) begin
      a = (i == 2);
      b = (i == 10);
      applyStimulus();
    end
    checkOutput("sp_pass_cnt", {16'b0, pass_cnt_0}, 32'd1);
    checkOutput("sp_fail_cnt", {16'b0, fail_cnt_0}, 32'd0);
    checkOutput("sp_err", {31'b0, err_0}, 32'd0);

    // Single fail: clear restarts the index at 0, trigger at index 2.
    idleMain();
    clrStep();
    for (int i = 0; i < 15; i++) begin
      a = (i == 2);
      b = 1'b0;
      applyStimulus();
    end
    checkOutput("sf_flags", {30'b0, err_0, ffv_0}, 32'd3);
    checkOutput("sf_ffc", {16'b0, ffc_0}, 32'd2);
    checkOutput("sf_fail_cnt", {16'b0, fail_cnt_0}, 32'd1);

    // Overlapping triggers at 0..19, response high from index 12.
    idleMain();
    clrStep();
    for (int i = 0; i < 30; i++) begin
      a = (i < 20);
      b = (i >= 12);
      applyStimulus();
    end
    checkOutput("ov_fail_cnt", {16'b0, fail_cnt_0}, 32'd4);
    checkOutput("ov_pass_cnt", {16'b0, pass_cnt_0}, 32'd16);
    checkOutput("ov_ffc", {16'b0, ffc_0}, 32'd0);

    // Reset mid-operation with five triggers outstanding; b stays low so any
    // leaked obligation would surface as a fail.
    idleMain();
    for (int i = 0; i < 5; i++) begin
      a = 1'b1;
      applyStimulus();
    end
    asyncReset();
    idleMain();
    for (int i = 0; i < 12; i++) applyStimulus();
    checkOutput("rr_fail_cnt", {16'b0, fail_cnt_0}, 32'd0);

    // Gating by en, then a pending trigger wiped by clr.
    clrStep();
    for (int i = 0; i < 41; i++) begin
      en  = (i >= 20);
      a   = (i < 20) || (i == 30);
      clr = (i == 33);
      b   = 1'b0;
      applyStimulus();
      if (i == 19) checkOutput("gate_busy", {31'b0, busy_0}, 32'd0);
      if (i == 33) checkOutput("clr_busy", {31'b0, busy_0}, 32'd0);
    end
    checkOutput("gc_cnts", {pass_cnt_0, fail_cnt_0}, 32'd0);
    idleMain();

    // Saturation on the 4-bit instance: 20 passing obligations.
    s_clr = 1'b1;
    applyStimulus();
    s_clr = 1'b0;
    s_en = 1'b1; s_b = 1'b1;
    for (int i = 0; i < 20 + D1 + 2; i++) begin
      s_a = (i < 20);
      applyStimulus();
    end
    checkOutput("sat_pass_cnt", {28'b0, pass_cnt_1}, 32'd15);
    s_a = 1'b0;

    // Random traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      en    = ($urandom_range(0, 9) < 8);
      a     = $urandom_range(0, 1);
      b     = ($urandom_range(0, 9) < 7);
      clr   = ($urandom_range(0, 63) == 0);
      s_en  = ($urandom_range(0, 9) < 8);
      s_a   = $urandom_range(0, 1);
      s_b   = ($urandom_range(0, 9) < 8);
      s_clr = ($urandom_range(0, 63) == 0);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
